quant_sramc_sched: RTL
======================

Name: quant_sramc_sched

Overview:
Scheduler for the SRAMC port behind the quantization pipeline. Shares the SRAM port between the quantized write/read stream (fixed latency, cannot be back-pressured) and a DMA requester (req/gnt). Tracks in-flight pipeline transactions, inserts entry stalls to break DMA starvation, and provides a flush/drain handshake. Sits between the quantization wrapper outputs, the accelerator issue point and the SRAM macro.

Parameters:
SRAMC_W, 1024, SRAM data width
ADRC_W, 12, SRAM address width
SRAMC_N, 32, write-mask elements
QLAT, 6, quantization pipeline latency in clocks
STARVE_MAX, 16, DMA wait cycles before forcing a pipeline bubble

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_acc_issue  in  1  accelerator presents an op (wren or rden) to the quantization pipeline
o_acc_stall  out  1  blocks accelerator issue; an op is accepted only when i_acc_issue & !o_acc_stall
i_q_wdata  in  SRAMC_W  quantized write data from pipeline
i_q_addr  in  ADRC_W  pipeline address
i_q_wren  in  1  pipeline write enable
i_q_wmask  in  SRAMC_N  pipeline write mask
i_q_rden  in  1  pipeline read enable
i_dma_req  in  1  DMA request (held until granted)
i_dma_we  in  1  DMA write(1)/read(0)
i_dma_addr  in  ADRC_W  DMA address
i_dma_wdata  in  SRAMC_W  DMA write data
i_dma_wmask  in  SRAMC_N  DMA write mask
o_dma_gnt  out  1  DMA op accepted this cycle
o_dma_rvalid  out  1  DMA read data valid
o_dma_rdata  out  SRAMC_W  DMA read data
o_sram_wdata  out  SRAMC_W  SRAM write data
o_sram_addr  out  ADRC_W  SRAM address
o_sram_wren  out  1  SRAM write enable
o_sram_wmask  out  SRAMC_N  SRAM write mask
o_sram_rden  out  1  SRAM read enable
i_sram_rdata  in  SRAMC_W  SRAM read data, valid 1 clock after o_sram_rden
i_flush_req  in  1  level request to drain the pipeline
o_flush_done  out  1  pipeline empty while flush held
o_inflight  out  $clog2(QLAT+1)  ops inside the pipeline
o_err  out  1  sticky in-flight counter underflow/overflow

Behaviour:
- Reset (async, i_rstn=0): every output 0, FSM=RUN, in-flight and starve counters 0, o_err 0.
- q_op = i_q_wren | i_q_rden. The pipeline always wins; it is never stalled at its output.
- o_dma_gnt (combinational) = i_dma_req & !q_op. At most one SRAM op per cycle.
- SRAM outputs registered: the winner's fields (q or DMA) appear on o_sram_* one clock later; with no winner, wren=rden=0 and data/addr/mask hold their last values.
- DMA read granted at T: o_sram_rden=1 at T+1, o_dma_rvalid=1 and o_dma_rdata=i_sram_rdata at T+2. Pipeline reads never raise o_dma_rvalid.
- In-flight: +1 on accepted issue, -1 on q_op, unchanged when both occur together. Decrement at 0 or increment at QLAT sets o_err; the counter saturates.
- Starve counter: +1 each cycle i_dma_req & !o_dma_gnt, saturating at STARVE_MAX; cleared on o_dma_gnt.
- FSM:
  - RUN: o_acc_stall=0. Go to FLUSH if i_flush_req; else to DRAIN when starve=STARVE_MAX.
  - DRAIN: o_acc_stall=1; go to RUN on o_dma_gnt (bubble reaches output within QLAT cycles). If i_flush_req, go to FLUSH.
  - FLUSH: o_acc_stall=1; DMA is still granted whenever q_op=0. o_flush_done=1 (registered) while o_inflight=0. Go to RUN when i_flush_req drops; o_flush_done=0 in the same cycle.
- FLUSH takes precedence over DRAIN when both conditions hold in the same cycle.
- A DMA request withdrawn before grant is a protocol violation; the request must be held until granted.

Test Plan:
- Reset mid-traffic (q_op and dma_req both active) -> all outputs 0 immediately; after release, FSM=RUN and counters 0.
- DMA write addr=0x010 with q idle at T -> o_dma_gnt@T; o_sram_wren=1, addr=0x010 at T+1; DMA read addr=0x010 -> o_dma_rvalid@T+2 with data equal to the written value.
- Back-to-back issue every cycle plus DMA req -> o_acc_stall rises 16 cycles after req; grant occurs at the first q idle cycle (≤6 cycles later); FSM returns to RUN and the starve counter reads 0.
- Same-cycle q_op and dma_req -> o_dma_gnt=0, SRAM carries the q fields.
- Flush after 4 accepted issues -> o_inflight counts down 4→0; o_flush_done=1 the cycle after it reaches 0; dropping flush -> stall=0, done=0.
- Inject q_op with o_inflight=0 -> o_err=1, held through further traffic until reset.

Source files
------------

// File: rtl/quant_sramc_sched.sv
// SRAM port scheduler behind the quantization pipeline: the fixed-latency pipeline always wins,
// DMA takes idle slots, and starvation or flush requests stall accelerator issue.
module quant_sramc_sched #(
    parameter int unsigned SRAMC_W    = 1024,
    parameter int unsigned ADRC_W     = 12,
    parameter int unsigned SRAMC_N    = 32,
    parameter int unsigned QLAT       = 6,
    parameter int unsigned STARVE_MAX = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_acc_issue,
    output logic                       o_acc_stall,
    input  logic [SRAMC_W-1:0]         i_q_wdata,
    input  logic [ADRC_W-1:0]          i_q_addr,
    input  logic                       i_q_wren,
    input  logic [SRAMC_N-1:0]         i_q_wmask,
    input  logic                       i_q_rden,
    input  logic                       i_dma_req,
    input  logic                       i_dma_we,
    input  logic [ADRC_W-1:0]          i_dma_addr,
    input  logic [SRAMC_W-1:0]         i_dma_wdata,
    input  logic [SRAMC_N-1:0]         i_dma_wmask,
    output logic                       o_dma_gnt,
    output logic                       o_dma_rvalid,
    output logic [SRAMC_W-1:0]         o_dma_rdata,
    output logic [SRAMC_W-1:0]         o_sram_wdata,
    output logic [ADRC_W-1:0]          o_sram_addr,
    output logic                       o_sram_wren,
    output logic [SRAMC_N-1:0]         o_sram_wmask,
    output logic                       o_sram_rden,
    input  logic [SRAMC_W-1:0]         i_sram_rdata,
    input  logic                       i_flush_req,
    output logic                       o_flush_done,
    output logic [$clog2(QLAT+1)-1:0]  o_inflight,
    output logic                       o_err
);

    localparam int unsigned IFW = $clog2(QLAT + 1);
    localparam int unsigned SW  = $clog2(STARVE_MAX + 1);
    localparam logic [IFW-1:0] InflightMax = IFW'(QLAT);
    localparam logic [SW-1:0]  StarveMax   = SW'(STARVE_MAX);

    typedef enum logic [1:0] {StRun, StDrain, StFlush} state_e;

    state_e         state_q, state_d;
    logic           q_op, gnt, acc, cnt_err;
    logic [IFW-1:0] inflight_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic           dma_rd_q;

    assign q_op = i_q_wren | i_q_rden;
    // Grant is combinational, so it is gated with reset to stay low while reset is held.
    assign gnt  = i_dma_req & ~q_op & i_rstn;
    assign acc  = i_acc_issue & ~o_acc_stall;

    assign o_dma_gnt   = gnt;
    assign o_dma_rdata = o_dma_rvalid ? i_sram_rdata : '0;

    always_comb begin
        inflight_d = o_inflight;
        cnt_err    = 1'b0;
        if (acc && !q_op) begin
            if (o_inflight == InflightMax) cnt_err = 1'b1;
            else                           inflight_d = o_inflight + IFW'(1);
        end else if (q_op && !acc) begin
            if (o_inflight == '0) cnt_err = 1'b1;
            else                  inflight_d = o_inflight - IFW'(1);
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (gnt) begin
            starve_d = '0;
        end else if (i_dma_req && (starve_q != StarveMax)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (i_flush_req)                 state_d = StFlush;
                else if (starve_q == StarveMax)  state_d = StDrain;
            end
            StDrain: begin
                if (i_flush_req) state_d = StFlush;
                else if (gnt)    state_d = StRun;
            end
            StFlush: begin
                if (!i_flush_req) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= StRun;
            o_acc_stall  <= 1'b0;
            o_flush_done <= 1'b0;
            o_inflight   <= '0;
            o_err        <= 1'b0;
            starve_q     <= '0;
            o_sram_wdata <= '0;
            o_sram_addr  <= '0;
            o_sram_wren  <= 1'b0;
            o_sram_wmask <= '0;
            o_sram_rden  <= 1'b0;
            dma_rd_q     <= 1'b0;
            o_dma_rvalid <= 1'b0;
        end else begin
            state_q      <= state_d;
            o_acc_stall  <= (state_d != StRun);
            // Done only while flush stays held and the pipeline was already empty.
            o_flush_done <= (state_q == StFlush) && (state_d == StFlush) && (o_inflight == '0);
            o_inflight   <= inflight_d;
            o_err        <= o_err | cnt_err;
            starve_q     <= starve_d;
            if (q_op) begin
                o_sram_wren  <= i_q_wren;
                o_sram_rden  <= i_q_rden;
                o_sram_addr  <= i_q_addr;
                o_sram_wdata <= i_q_wdata;
                o_sram_wmask <= i_q_wmask;
            end else if (gnt) begin
                o_sram_wren  <= i_dma_we;
                o_sram_rden  <= ~i_dma_we;
                o_sram_addr  <= i_dma_addr;
                o_sram_wdata <= i_dma_wdata;
                o_sram_wmask <= i_dma_wmask;
            end else begin
                o_sram_wren  <= 1'b0;
                o_sram_rden  <= 1'b0;
            end
            dma_rd_q     <= gnt & ~i_dma_we;
            o_dma_rvalid <= dma_rd_q;
        end
    end

endmodule
